// File: rtl/alu_instr_decoder.sv
// ============================================================================
//  Module   : alu_instr_decoder
//  Purpose  : Registered RV32I decode stage with a two-entry skid buffer that
//             feeds the ALU its opcode/funct/immediate/register fields.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_instr_decoder #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 7,
    parameter int FUNCT3_LENGTH = 3,
    parameter int FUNCT7_LENGTH = 7,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    in_instr,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Opcode,
    output logic [FUNCT3_LENGTH-1:0] Funct3,
    output logic [FUNCT7_LENGTH-1:0] Funct7,
    output logic [11:0]              immI,
    output logic [19:0]              immU,
    output logic [4:0]               rs1_addr,
    output logic [4:0]               rs2_addr,
    output logic [4:0]               rd_addr,
    output logic                     illegal,
    output logic [COUNT_WIDTH-1:0]   decoded_count,
    output logic [7:0]               illegal_count
);

    localparam int c_ILL_CNT_WIDTH = 8;

    localparam logic [OPCODE_LENGTH-1:0] c_OP_R     = 7'b0110011;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_IMM   = 7'b0010011;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_LUI   = 7'b0110111;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_AUIPC = 7'b0010111;

    localparam logic [FUNCT7_LENGTH-1:0] c_F7_BASE  = 7'b0000000;
    localparam logic [FUNCT7_LENGTH-1:0] c_F7_ALT   = 7'b0100000;

    localparam logic [FUNCT3_LENGTH-1:0] c_F3_ADD   = 3'b000;
    localparam logic [FUNCT3_LENGTH-1:0] c_F3_SLL   = 3'b001;
    localparam logic [FUNCT3_LENGTH-1:0] c_F3_SR    = 3'b101;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [OPCODE_LENGTH-1:0] w_opcode;
    logic [FUNCT3_LENGTH-1:0] w_funct3;
    logic [FUNCT7_LENGTH-1:0] w_funct7;
    logic                     w_illegal;

    assign w_opcode = in_instr[OPCODE_LENGTH-1:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[DATA_WIDTH-1:DATA_WIDTH-FUNCT7_LENGTH];

    always_comb begin
        w_illegal = 1'b1;
        case (w_opcode)
            c_OP_R: begin
                // The alternate funct7 only selects SUB and SRA
                w_illegal = !((w_funct7 == c_F7_BASE) ||
                              ((w_funct7 == c_F7_ALT) &&
                               ((w_funct3 == c_F3_ADD) || (w_funct3 == c_F3_SR))));
            end
            c_OP_IMM: begin
                case (w_funct3)
                    c_F3_SLL: w_illegal = (w_funct7 != c_F7_BASE);
                    c_F3_SR:  w_illegal = !((w_funct7 == c_F7_BASE) ||
                                            (w_funct7 == c_F7_ALT));
                    default:  w_illegal = 1'b0;
                endcase
            end
            c_OP_LUI:   w_illegal = 1'b0;
            c_OP_AUIPC: w_illegal = 1'b0;
            default:    w_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Buffer state and storage
    // ------------------------------------------------------------------
    state_t                     state_q,      state_d;
    logic                       in_ready_q,   in_ready_d;
    logic [DATA_WIDTH-1:0]      main_instr_q, main_instr_d;
    logic                       main_ill_q,   main_ill_d;
    logic [DATA_WIDTH-1:0]      skid_instr_q, skid_instr_d;
    logic                       skid_ill_q,   skid_ill_d;
    logic [COUNT_WIDTH-1:0]     dec_cnt_q,    dec_cnt_d;
    logic [c_ILL_CNT_WIDTH-1:0] ill_cnt_q,    ill_cnt_d;

    logic w_accept;
    logic w_pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q & ~flush;
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_ill_d   = main_ill_q;
        skid_instr_d = skid_instr_q;
        skid_ill_d   = skid_ill_q;
        dec_cnt_d    = dec_cnt_q;
        ill_cnt_d    = ill_cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    main_instr_d = in_instr;
                    main_ill_d   = w_illegal;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    main_instr_d = in_instr;
                    main_ill_d   = w_illegal;
                end else if (w_accept) begin
                    skid_instr_d = in_instr;
                    skid_ill_d   = w_illegal;
                    state_d      = ST_TWO;
                end else if (w_pop) begin
                    state_d      = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    main_instr_d = skid_instr_q;
                    main_ill_d   = skid_ill_q;
                    state_d      = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (w_accept) begin
            dec_cnt_d = dec_cnt_q + COUNT_WIDTH'(1);
            if (w_illegal && (ill_cnt_q != {c_ILL_CNT_WIDTH{1'b1}})) begin
                ill_cnt_d = ill_cnt_q + c_ILL_CNT_WIDTH'(1);
            end
        end

        // Flush discards buffered entries but leaves the counters alone
        if (flush) begin
            state_d    = ST_EMPTY;
            main_ill_d = 1'b0;
            skid_ill_d = 1'b0;
        end
    end

    assign in_ready_d = (state_d != ST_TWO);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            main_instr_q <= '0;
            main_ill_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_ill_q   <= 1'b0;
            dec_cnt_q    <= '0;
            ill_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            main_instr_q <= main_instr_d;
            main_ill_q   <= main_ill_d;
            skid_instr_q <= skid_instr_d;
            skid_ill_q   <= skid_ill_d;
            dec_cnt_q    <= dec_cnt_d;
            ill_cnt_q    <= ill_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Field outputs come straight from the main entry
    // ------------------------------------------------------------------
    assign Opcode        = main_instr_q[OPCODE_LENGTH-1:0];
    assign Funct3        = main_instr_q[14:12];
    assign Funct7        = main_instr_q[DATA_WIDTH-1:DATA_WIDTH-FUNCT7_LENGTH];
    assign immI          = main_instr_q[31:20];
    assign immU          = main_instr_q[31:12];
    assign rs1_addr      = main_instr_q[19:15];
    assign rs2_addr      = main_instr_q[24:20];
    assign rd_addr       = main_instr_q[11:7];
    assign illegal       = main_ill_q;
    assign decoded_count = dec_cnt_q;
    assign illegal_count = ill_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_instr_decoder.sv
// ============================================================================
//  Module   : tb_alu_instr_decoder
//  Purpose  : Self-checking bench: vector table, directed corner sequences and
//             randomized traffic against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_instr_decoder;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  Opcode;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic [11:0] immI;
    logic [19:0] immU;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        illegal;
    logic [15:0] decoded_count;
    logic [7:0]  illegal_count;

    alu_instr_decoder dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .in_instr      (in_instr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .Opcode        (Opcode),
        .Funct3        (Funct3),
        .Funct7        (Funct7),
        .immI          (immI),
        .immU          (immU),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rd_addr       (rd_addr),
        .illegal       (illegal),
        .decoded_count (decoded_count),
        .illegal_count (illegal_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference legality rule, stated as sets of allowed encodings
    function automatic bit ref_illegal(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        bit r_ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        bit i_ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                   (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        bit legal = (op == 7'h37) || (op == 7'h17) ||
                    (op == 7'h33 && r_ok) || (op == 7'h13 && i_ok);
        return !legal;
    endfunction

    typedef struct {
        logic [31:0] instr;
        bit          ill;
    } ent_t;

    ent_t q[$];
    int   m_dec = 0;
    int   m_ill = 0;

    // Monitor: compare against the model mid-cycle, then advance the model
    always @(negedge clock) begin
        bit exp_valid, exp_ready, acc, pop;
        if (reset) begin
            q.delete();
            m_dec = 0;
            m_ill = 0;
        end else begin
            exp_valid = (q.size() > 0);
            exp_ready = (q.size() < 2) && !flush;
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            chk("decoded_count", {16'd0, decoded_count}, m_dec % 65536);
            chk("illegal_count", {24'd0, illegal_count}, m_ill);
            if (exp_valid) begin
                chk("Opcode", {25'd0, Opcode}, {25'd0, q[0].instr[6:0]});
                chk("Funct3", {29'd0, Funct3}, {29'd0, q[0].instr[14:12]});
                chk("Funct7", {25'd0, Funct7}, {25'd0, q[0].instr[31:25]});
                chk("immI", {20'd0, immI}, q[0].instr >> 20);
                chk("immU", {12'd0, immU}, q[0].instr >> 12);
                chk("rs1", {27'd0, rs1_addr}, {27'd0, q[0].instr[19:15]});
                chk("rs2", {27'd0, rs2_addr}, {27'd0, q[0].instr[24:20]});
                chk("rd", {27'd0, rd_addr}, {27'd0, q[0].instr[11:7]});
                chk("illegal", {31'd0, illegal}, {31'd0, q[0].ill});
            end
            acc = in_valid && exp_ready;
            pop = exp_valid && out_ready;
            if (pop) void'(q.pop_front());
            if (acc) begin
                ent_t e;
                e.instr = in_instr;
                e.ill   = ref_illegal(in_instr);
                q.push_back(e);
                m_dec++;
                if (e.ill && m_ill < 255) m_ill++;
            end
            if (flush) q.delete();
        end
    end

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer one word and wait (bounded) until it is accepted
    task automatic push(input logic [31:0] w);
        bit done = 0;
        in_valid = 1'b1;
        in_instr = w;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (in_ready) done = 1;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL push_timeout: instr 0x%0h not accepted within 20 cycles", w);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w = $urandom;
        logic [6:0] ops[5] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h00};
        logic [6:0] op = ops[$urandom_range(0, 4)];
        if (op == 7'h00) op = 7'($urandom);
        w[6:0] = op;
        case ($urandom_range(0, 3))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            default: w[31:25] = 7'($urandom);
        endcase
        return w;
    endfunction

    initial begin
        int base;
        vecs[0]  = '{32'h002081B3, 7'h33, 5'd3, 1'b0};  // add x3,x1,x2
        vecs[1]  = '{32'h407302B3, 7'h33, 5'd5, 1'b0};  // sub
        vecs[2]  = '{32'hFFF00093, 7'h13, 5'd1, 1'b0};  // addi x1,x0,-1
        vecs[3]  = '{32'h12345137, 7'h37, 5'd2, 1'b0};  // lui
        vecs[4]  = '{32'h02208133, 7'h33, 5'd2, 1'b1};  // funct7=0000001
        vecs[5]  = '{32'h40209093, 7'h13, 5'd1, 1'b1};  // slli with alt funct7
        vecs[6]  = '{32'h00000017, 7'h17, 5'd0, 1'b0};  // auipc
        vecs[7]  = '{32'h0000007F, 7'h7F, 5'd0, 1'b1};  // unknown opcode
        vecs[8]  = '{32'h40005013, 7'h13, 5'd0, 1'b0};  // srai
        vecs[9]  = '{32'h40001033, 7'h33, 5'd0, 1'b1};  // sll with alt funct7
        vecs[10] = '{32'h42001013, 7'h13, 5'd0, 1'b1};  // slli bad funct7

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_opcode", {25'd0, Opcode}, 32'd0);
        chk("rst_immU", {12'd0, immU}, 32'd0);
        chk("rst_rd", {27'd0, rd_addr}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        step();

        // Table vectors, one at a time
        for (int i = 0; i < 11; i++) begin
            push(vecs[i].instr);
            @(negedge clock);
            chk("vec_opcode", {25'd0, Opcode}, {25'd0, vecs[i].opcode});
            chk("vec_rd", {27'd0, rd_addr}, {27'd0, vecs[i].rd});
            chk("vec_illegal", {31'd0, illegal}, {31'd0, vecs[i].ill});
            if (i == 0) chk("vec_first_count", {16'd0, decoded_count}, 32'd1);
            if (i == 3) chk("vec_lui_immU", {12'd0, immU}, 32'h12345);
            step();
        end
        chk("vec_illegal_count", {24'd0, illegal_count}, 32'd5);

        // Back-to-back SUB then ADDI with no bubble
        drain();
        in_valid = 1'b1; in_instr = 32'h407302B3; step();
        in_instr = 32'hFFF00093; step();
        in_valid = 1'b0;
        @(negedge clock);
        chk("b2b_addi_immI", {20'd0, immI}, 32'hFFF);
        chk("b2b_addi_valid", {31'd0, out_valid}, 32'd1);

        // Back-pressure: A, B accepted, C held until the skid drains
        drain();
        base = decoded_count;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; step();
        in_instr = 32'h00200113; step();
        in_instr = 32'h00300193;
        repeat (3) begin
            @(negedge clock);
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step(); step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("bp_count", decoded_count - base, 32'd3);

        // Flush while holding two entries
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h02208133; step();
        in_instr = 32'h00500293; step();
        base = decoded_count;
        flush = 1'b1; in_instr = 32'h00600313;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_count", {16'd0, decoded_count}, base);
        step();

        // Randomized traffic, including flushes; long enough to saturate illegal_count
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = gen_instr();
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0;
        drain();
        chk("rand_ill_saturated", {24'd0, illegal_count}, 32'hFF);

        // Reset wins over an offered instruction and clears the counters
        in_valid = 1'b1; in_instr = 32'h002081B3; reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("rst2_dec_count", {16'd0, decoded_count}, 32'd0);
        chk("rst2_ill_count", {24'd0, illegal_count}, 32'd0);
        chk("rst2_opcode", {25'd0, Opcode}, 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
